sipo_deser: RTL
===============

Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer; the receive end of the team's LSB-first PISO serial link.
- Samples one bit per enabled rising clock edge and assembles WIDTH bits into a parallel word.
- Presents each completed word through a valid/ready hold register and flags overrun when a word is lost.
- Sits between the serial line and any parallel consumer, such as a register file or ALU operand latch.

Parameters:
- WIDTH, 4, data bits per word; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data in, LSB first.
- shift_en  input  1  sin carries a valid bit this cycle.
- align  input  1  synchronous frame restart; discards any partial word.
- dout  output  WIDTH  assembled parallel word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout at this edge.
- busy  output  1  a partial word is in progress.
- overrun  output  1  sticky flag: a completed word was dropped.
- parity_err  output  1  parity check result for dout (see Optional Feature).

Behaviour:
- Reset: rst_n=0 asynchronously clears the shift register, bit counter, state, dout, dout_valid, overrun and parity_err to 0; state goes to IDLE.
  - Reset mid-frame discards the partial word with no further side effect.
- Clocking: single clock; all registers update on the rising edge of clk; no negedge logic.
  - The transmitter drives sin on the falling edge, so the receiver samples mid-bit.
- Sampling: on an edge with shift_en=1 and align=0:
  - shreg <= {sin, shreg[WIDTH-1:1]} (right shift, new bit enters at the MSB).
  - After WIDTH samples, the first received bit is in bit 0.
  - cnt increments on each sample.
- States:
  - IDLE (cnt=0): the first sample moves to SHIFT.
  - SHIFT: the sample with cnt=WIDTH-1 completes the data bits; next state is IDLE, or PAR when the parity feature is on.
  - PAR: one parity sample, then back to IDLE.
  - busy=1 in SHIFT and PAR, otherwise 0.
- Completion: at the completing edge, the word {sin, shreg[WIDTH-1:1]} is offered to the hold register and cnt wraps to 0.
  - Latency: dout and dout_valid are visible immediately after the edge that samples the last data bit (or the parity bit, with parity on).
- Hold register rules:
  - dout_valid=1 and dout_ready=1 at an edge: word consumed; dout_valid clears unless a new word completes at the same edge.
  - Completion with dout_valid=0: dout loads, dout_valid=1.
  - Completion with dout_valid=1 and dout_ready=1 at the same edge: dout loads the new word, dout_valid stays 1, no overrun.
  - Completion with dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, overrun is set.
- overrun: sticky; cleared only by align=1 or rst_n.
- align=1:
  - cnt=0, state=IDLE, overrun=0.
  - Takes priority over shift_en: a bit presented in the same cycle is discarded.
  - Does not affect dout or dout_valid.
- shift_en=0: no state change apart from hold-register consumption.
- dout_ready with dout_valid=0: ignored.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame carries one extra bit after the data bits: an even-parity bit, so the XOR of all data bits and the parity bit is 0.
  - The word completes at the parity sample.
  - parity_err is registered with dout: it is 1 when the XOR is 1 and is meaningful while dout_valid=1.
  - A dropped (overrun) word does not update parity_err.
- Undefined:
  - PAR state is absent and the word completes after WIDTH bits.
  - parity_err is tied to 0.

Test Plan:
- Reset: rst_n=0 after 2 of 4 bits sampled -> busy, dout, dout_valid and overrun are 0 at once; the next 4 bits 1,1,0,0 -> dout=4'h3.
- Basic: WIDTH=4, shift_en=1, sin=1,0,1,1 on four edges -> dout=4'hD, dout_valid=1 after the 4th edge; busy=1 after edges 1-3 and 0 after edge 4.
- Overrun: hold 4'hD with dout_ready=0, then shift 0,1,1,0 -> dout stays 4'hD, overrun=1; then pulse align -> overrun=0, dout_valid still 1.
- Back-to-back: dout_ready=1 on the edge that completes the next word 0,0,1,0 -> dout=4'h4, dout_valid stays 1, overrun=0.
- Align: 2 bits sampled, then align=1 with shift_en=1 (bit discarded), then 1,1,1,0 -> dout=4'h7.
- Parity (SIPO_PARITY_EN): data 1,0,1,1 + parity 1 -> dout=4'hD, parity_err=0; data 1,0,1,1 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_deser_if.sv
// Parallel-side bundle of the LSB-first serial deserializer.
// The master modport is the deserializer; slave is the line driver / consumer.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             shift_en;
  logic             align;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    input  sin,
    input  shift_en,
    input  align,
    input  dout_ready,
    output dout,
    output dout_valid,
    output busy,
    output overrun,
    output parity_err
  );

  modport slave (
    output sin,
    output shift_en,
    output align,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  overrun,
    input  parity_err
  );
endinterface

// File: rtl/sipo_deser.sv
// LSB-first serial-in/parallel-out deserializer with valid/ready hold register and
// sticky overrun. Define SIPO_PARITY_EN for a trailing even-parity bit per frame.
module sipo_deser #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sipo_deser_if.master bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  // The whole data word must stay in the shifter until the parity sample.
  localparam int unsigned SW = WIDTH;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
  // The last data bit goes straight from sin into the word, so one bit less is stored.
  localparam int unsigned SW = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q;
  logic [SW-1:0]    shreg_q;
  logic [SW-1:0]    shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             busy_q;
  logic             ovr_q;
  logic             sample;
  logic             consume;
  logic             complete_d;
  logic [WIDTH-1:0] word_d;
`ifdef SIPO_PARITY_EN
  logic             perr_q;
  logic             perr_d;
`endif

  assign sample  = bus.shift_en & ~bus.align;
  assign consume = valid_q & bus.dout_ready;
  assign shreg_d = SW'({bus.sin, shreg_q} >> 1);

  always_comb begin
    complete_d = 1'b0;
`ifdef SIPO_PARITY_EN
    word_d     = shreg_q;
    perr_d     = (^shreg_q) ^ bus.sin;
    if (sample && state_q == PAR) begin
      complete_d = 1'b1;
    end
`else
    word_d     = {bus.sin, shreg_q};
    if (sample && state_q == SHIFT && cnt_q == LAST) begin
      complete_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      if (consume) begin
        valid_q <= 1'b0;
      end

      if (bus.align) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end else if (bus.shift_en) begin
        shreg_q <= shreg_d;
        unique case (state_q)
          IDLE: begin
            state_q <= SHIFT;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
          end
          SHIFT: begin
            if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_EN
              state_q <= PAR;
              cnt_q   <= cnt_q + CW'(1);
`else
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
`endif
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end

      // A completing word replaces a word being consumed at the same edge.
      if (complete_d) begin
        if (!valid_q || bus.dout_ready) begin
          dout_q  <= word_d;
          valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
          perr_q  <= perr_d;
`endif
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = ovr_q;
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
